// File: rtl/hazard_scheduler_if.sv
// Purpose : decode-side bundle between the instruction decoder and hazard_scheduler.
// Latency : wires only; no state.
// Backpres: none; stall/flushID flow back to the decoder and PC logic.
// Ports   : master = decoder/EX side (drives decode fields and brTaken),
//           slave  = scheduler (drives stall, flushID, pcSel and the forward selects).
interface hazard_scheduler_if #(
  parameter int REG_ADDR_WIDTH = 4
);
  logic                      instValid;
  logic [REG_ADDR_WIDTH-1:0] dRegAddr;
  logic [REG_ADDR_WIDTH-1:0] s1RegAddr;
  logic [REG_ADDR_WIDTH-1:0] s2RegAddr;
  logic                      s1Used;
  logic                      s2Used;
  logic                      regFileWrtEn;
  logic                      isLoad;
  logic                      brTaken;
  logic                      stall;
  logic                      flushID;
  logic                      pcSel;
  logic [1:0]                s1Fwd;
  logic [1:0]                s2Fwd;

  modport master (
    output instValid, dRegAddr, s1RegAddr, s2RegAddr, s1Used, s2Used,
           regFileWrtEn, isLoad, brTaken,
    input  stall, flushID, pcSel, s1Fwd, s2Fwd
  );

  modport slave (
    input  instValid, dRegAddr, s1RegAddr, s2RegAddr, s1Used, s2Used,
           regFileWrtEn, isLoad, brTaken,
    output stall, flushID, pcSel, s1Fwd, s2Fwd
  );
endinterface

// File: rtl/hazard_scheduler.sv
// Purpose : EX/MEM writer scoreboard, operand forwarding, load-use stall and branch flush.
// Latency : all outputs combinational from current decode inputs and registered state.
// Backpres: stall holds PC and IF/ID for one cycle per load-use hazard; a flush always wins.
// Ports   : clk, reset (sync, active-high); hs (slave modport of hazard_scheduler_if);
//           stallCount / flushCount saturating counts of cycles with stall / flushID high.
module hazard_scheduler #(
  parameter int REG_ADDR_WIDTH = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_scheduler_if.slave    hs,
  output logic [CNT_WIDTH-1:0] stallCount,
  output logic [CNT_WIDTH-1:0] flushCount
);

  typedef enum logic {RUN = 1'b0, KILL = 1'b1} state_t;

  typedef struct packed {
    logic                      vld;
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic                      is_load;
  } ex_slot_t;

  // Once a load reaches MEM its data is forwardable, so the load flag is not kept there.
  typedef struct packed {
    logic                      vld;
    logic [REG_ADDR_WIDTH-1:0] addr;
  } mem_slot_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t    state;
  ex_slot_t  ex_slot;
  mem_slot_t mem_slot;

  logic s1_ex, s2_ex, s1_mem, s2_mem;
  logic load_use, flush, redirect, stall_int;

  assign s1_ex  = hs.s1Used & ex_slot.vld  & (hs.s1RegAddr == ex_slot.addr);
  assign s2_ex  = hs.s2Used & ex_slot.vld  & (hs.s2RegAddr == ex_slot.addr);
  assign s1_mem = hs.s1Used & mem_slot.vld & (hs.s1RegAddr == mem_slot.addr);
  assign s2_mem = hs.s2Used & mem_slot.vld & (hs.s2RegAddr == mem_slot.addr);

  assign load_use = hs.instValid & ex_slot.is_load & (s1_ex | s2_ex);

  // KILL flushes the second younger instruction regardless of brTaken (EX holds a bubble).
  // Outputs are forced quiet during the reset cycle so stale state cannot leak out.
  assign flush     = ~reset & ((state == KILL) | hs.brTaken);
  assign redirect  = ~reset & (state == RUN) & hs.brTaken;
  assign stall_int = ~reset & load_use & ~flush;

  // A load in EX cannot forward yet; that case falls through to MEM or the regfile
  // while the stall holds decode.
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic ex_is_load,
                                         input logic mem_hit);
    if (ex_hit && !ex_is_load) return 2'b01;
    else if (mem_hit)          return 2'b10;
    else                       return 2'b00;
  endfunction

  assign hs.stall   = stall_int;
  assign hs.flushID = flush;
  assign hs.pcSel   = redirect;
  assign hs.s1Fwd   = reset ? 2'b00 : fwd_sel(s1_ex, ex_slot.is_load, s1_mem);
  assign hs.s2Fwd   = reset ? 2'b00 : fwd_sel(s2_ex, ex_slot.is_load, s2_mem);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      ex_slot    <= '0;
      mem_slot   <= '0;
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      mem_slot <= mem_slot_t'{vld: ex_slot.vld, addr: ex_slot.addr};
      if (stall_int || flush)
        ex_slot <= '0;
      else
        ex_slot <= ex_slot_t'{vld:     hs.instValid & hs.regFileWrtEn,
                              addr:    hs.dRegAddr,
                              is_load: hs.isLoad};
      state <= redirect ? KILL : RUN;
      if (stall_int && stallCount != CNT_MAX) stallCount <= stallCount + CNT_WIDTH'(1);
      if (flush && flushCount != CNT_MAX)     flushCount <= flushCount + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Purpose : self-checking bench for hazard_scheduler (directed scenarios + random vs model).
// Latency : checks sample 1 time unit after the falling edge, before the next rising edge.
// Backpres: a stalled decode instruction is re-presented unchanged in the random run.
module tb_hazard_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_scheduler_if #(.REG_ADDR_WIDTH(4)) hif ();
  hazard_scheduler_if #(.REG_ADDR_WIDTH(4)) hifs ();
  logic [15:0] stallCount, flushCount;
  logic [3:0]  stallCount_s, flushCount_s;

  hazard_scheduler #(.REG_ADDR_WIDTH(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .hs(hif.slave),
    .stallCount(stallCount), .flushCount(flushCount));

  hazard_scheduler #(.REG_ADDR_WIDTH(4), .CNT_WIDTH(4)) dut_small (
    .clk(clk), .reset(reset), .hs(hifs.slave),
    .stallCount(stallCount_s), .flushCount(flushCount_s));

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  // History of the last two instructions that actually entered EX (index 0 youngest).
  typedef struct { bit wr; int rd; bit ld; } ent_t;
  ent_t m_hist[2];
  bit   m_kill;        // a branch redirected last cycle, so one more victim to kill
  int   m_stall_cnt, m_flush_cnt;
  localparam int CMAX = 65535;
  bit       exp_stall, exp_flush, exp_pc;
  bit [1:0] exp_s1, exp_s2;

  task automatic model_expect();
    bit m1e, m2e, m1m, m2m;
    m1e = hif.s1Used && m_hist[0].wr && (int'(hif.s1RegAddr) == m_hist[0].rd);
    m2e = hif.s2Used && m_hist[0].wr && (int'(hif.s2RegAddr) == m_hist[0].rd);
    m1m = hif.s1Used && m_hist[1].wr && (int'(hif.s1RegAddr) == m_hist[1].rd);
    m2m = hif.s2Used && m_hist[1].wr && (int'(hif.s2RegAddr) == m_hist[1].rd);
    if (reset) begin
      exp_stall = 0; exp_flush = 0; exp_pc = 0; exp_s1 = 0; exp_s2 = 0;
    end else begin
      exp_flush = m_kill || hif.brTaken;
      exp_pc    = !m_kill && hif.brTaken;
      exp_stall = hif.instValid && m_hist[0].ld && (m1e || m2e) && !exp_flush;
      exp_s1    = (m1e && !m_hist[0].ld) ? 2'b01 : (m1m ? 2'b10 : 2'b00);
      exp_s2    = (m2e && !m_hist[0].ld) ? 2'b01 : (m2m ? 2'b10 : 2'b00);
    end
  endtask

  task automatic tick();
    ent_t e;
    model_expect();
    @(posedge clk);
    if (reset) begin
      m_hist[0] = '{0, 0, 0}; m_hist[1] = '{0, 0, 0};
      m_kill = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      e.wr = !exp_stall && !exp_flush && hif.instValid && hif.regFileWrtEn;
      e.rd = int'(hif.dRegAddr);
      e.ld = hif.isLoad;
      m_hist[1] = m_hist[0];
      m_hist[0] = e;
      m_kill = exp_pc;
      if (exp_stall && m_stall_cnt < CMAX) m_stall_cnt++;
      if (exp_flush && m_flush_cnt < CMAX) m_flush_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit iv, input int d, input int s1, input int s2,
                       input bit u1, input bit u2, input bit we, input bit ld, input bit br);
    hif.instValid    = iv;
    hif.dRegAddr     = d[3:0];
    hif.s1RegAddr    = s1[3:0];
    hif.s2RegAddr    = s2[3:0];
    hif.s1Used       = u1;
    hif.s2Used       = u2;
    hif.regFileWrtEn = we;
    hif.isLoad       = ld;
    hif.brTaken      = br;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_dut();
    reset = 1; idle(); tick(); tick();
    reset = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1;
    drive(1, 3, 3, 3, 1, 1, 1, 1, 0);
    #1;
    n_checks++;
    if ({hif.stall, hif.flushID, hif.pcSel, hif.s1Fwd, hif.s2Fwd} !== 7'b0) begin
      n_errors++; $display("FAIL reset_outputs: got %b want 0000000",
        {hif.stall, hif.flushID, hif.pcSel, hif.s1Fwd, hif.s2Fwd});
    end
    tick(); tick();
    reset = 0;
    drive(1, 2, 3, 0, 1, 1, 1, 0, 0);
    #1;
    n_checks++;
    if ({hif.stall, hif.flushID, hif.pcSel, hif.s1Fwd, hif.s2Fwd} !== 7'b0) begin
      n_errors++; $display("FAIL post_reset_outputs: got %b want 0000000",
        {hif.stall, hif.flushID, hif.pcSel, hif.s1Fwd, hif.s2Fwd});
    end
    n_checks++;
    if ({stallCount, flushCount} !== 32'h0) begin
      n_errors++; $display("FAIL reset_counters: got %h/%h want 0/0", stallCount, flushCount);
    end
    tick();
  endtask

  task automatic test_ex_forward();
    reset_dut();
    drive(1, 3, 1, 2, 1, 1, 1, 0, 0); tick();          // ADD r3
    drive(1, 4, 3, 3, 1, 1, 1, 0, 0); #1;              // reads r3 twice
    n_checks++;
    if ({hif.stall, hif.s1Fwd, hif.s2Fwd} !== 5'b0_01_01) begin
      n_errors++; $display("FAIL ex_forward: got stall=%b s1=%b s2=%b want 0/01/01",
        hif.stall, hif.s1Fwd, hif.s2Fwd);
    end
    tick();
  endtask

  task automatic test_mem_forward();
    reset_dut();
    drive(1, 6, 1, 2, 1, 1, 1, 0, 0); tick();          // ADD r6
    drive(1, 7, 1, 2, 1, 1, 1, 0, 0); tick();          // unrelated
    drive(1, 9, 6, 2, 1, 1, 1, 0, 0); #1;
    n_checks++;
    if ({hif.s1Fwd, hif.s2Fwd} !== 4'b10_00) begin
      n_errors++; $display("FAIL mem_forward: got s1=%b s2=%b want 10/00", hif.s1Fwd, hif.s2Fwd);
    end
    tick();
    // EX wins over MEM when both hold the same destination
    drive(1, 8, 1, 1, 1, 1, 1, 0, 0); tick();
    drive(1, 8, 1, 1, 1, 1, 1, 0, 0); tick();
    drive(1, 2, 0, 8, 0, 1, 1, 0, 0); #1;
    n_checks++;
    if ({hif.s1Fwd, hif.s2Fwd} !== 4'b00_01) begin
      n_errors++; $display("FAIL ex_priority: got s1=%b s2=%b want 00/01", hif.s1Fwd, hif.s2Fwd);
    end
    tick();
  endtask

  task automatic test_load_use();
    reset_dut();
    drive(1, 5, 2, 0, 1, 0, 1, 1, 0); tick();          // LW r5
    drive(1, 9, 1, 5, 1, 1, 1, 0, 0); #1;              // ADD reads r5
    n_checks++;
    if ({hif.stall, hif.flushID, hif.s2Fwd} !== 4'b1_0_00) begin
      n_errors++; $display("FAIL load_use_stall: got stall=%b flush=%b s2=%b want 1/0/00",
        hif.stall, hif.flushID, hif.s2Fwd);
    end
    tick();                                            // same instruction re-presented
    #1;
    n_checks++;
    if ({hif.stall, hif.s2Fwd} !== 3'b0_10) begin
      n_errors++; $display("FAIL load_use_replay: got stall=%b s2=%b want 0/10", hif.stall, hif.s2Fwd);
    end
    n_checks++;
    if (stallCount !== 16'd1) begin
      n_errors++; $display("FAIL load_use_count: got %0d want 1", stallCount);
    end
    tick();
    idle(); #1;                                        // bubble went to EX, ADD in EX is not a load
    n_checks++;
    if (hif.stall !== 1'b0) begin
      n_errors++; $display("FAIL load_use_once: got stall=%b want 0", hif.stall);
    end
    tick();
  endtask

  task automatic test_immediate();
    reset_dut();
    drive(1, 5, 2, 0, 1, 0, 1, 1, 0); tick();          // LW r5
    drive(1, 6, 2, 5, 1, 0, 1, 0, 0); #1;              // ADDI, s2 field = r5 but unused
    n_checks++;
    if ({hif.stall, hif.s1Fwd, hif.s2Fwd} !== 5'b0_00_00) begin
      n_errors++; $display("FAIL immediate_form: got stall=%b s1=%b s2=%b want 0/00/00",
        hif.stall, hif.s1Fwd, hif.s2Fwd);
    end
    tick();
  endtask

  task automatic test_branch();
    reset_dut();
    drive(1, 3, 1, 2, 1, 1, 1, 0, 1); #1;
    n_checks++;
    if ({hif.pcSel, hif.flushID, hif.stall} !== 3'b110) begin
      n_errors++; $display("FAIL branch_first: got pc=%b flush=%b stall=%b want 1/1/0",
        hif.pcSel, hif.flushID, hif.stall);
    end
    tick();
    drive(1, 3, 1, 2, 1, 1, 1, 0, 1); #1;              // brTaken in KILL is ignored
    n_checks++;
    if ({hif.pcSel, hif.flushID} !== 2'b01) begin
      n_errors++; $display("FAIL branch_kill: got pc=%b flush=%b want 0/1", hif.pcSel, hif.flushID);
    end
    tick();
    idle(); #1;
    n_checks++;
    if ({hif.pcSel, hif.flushID} !== 2'b00) begin
      n_errors++; $display("FAIL branch_done: got pc=%b flush=%b want 0/0", hif.pcSel, hif.flushID);
    end
    n_checks++;
    if (flushCount !== 16'd2) begin
      n_errors++; $display("FAIL branch_count: got %0d want 2", flushCount);
    end
    tick();
  endtask

  task automatic test_branch_load_use();
    reset_dut();
    drive(1, 5, 2, 0, 1, 0, 1, 1, 0); tick();          // LW r5
    drive(1, 9, 5, 0, 1, 0, 1, 0, 1); #1;              // consumer + branch
    n_checks++;
    if ({hif.stall, hif.flushID} !== 2'b01) begin
      n_errors++; $display("FAIL branch_vs_stall: got stall=%b flush=%b want 0/1", hif.stall, hif.flushID);
    end
    tick();
    // Reset during KILL: reset cycle quiet, next cycle no residual flush.
    reset = 1; idle(); #1;
    n_checks++;
    if ({hif.stall, hif.flushID, hif.pcSel} !== 3'b000) begin
      n_errors++; $display("FAIL reset_in_kill: got stall=%b flush=%b pc=%b want 0/0/0",
        hif.stall, hif.flushID, hif.pcSel);
    end
    tick();
    reset = 0; idle(); #1;
    n_checks++;
    if ({hif.flushID, stallCount, flushCount} !== 33'h0) begin
      n_errors++; $display("FAIL after_kill_reset: got flush=%b counts=%0d/%0d want 0/0/0",
        hif.flushID, stallCount, flushCount);
    end
    tick();
  endtask

  task automatic test_random();
    bit prev_stall = 0;
    reset_dut();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      if (!prev_stall)
        drive($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 0);
      hif.brTaken = ($urandom_range(0, 7) == 0);
      #1;
      model_expect();
      n_checks++;
      if ({hif.stall, hif.flushID, hif.pcSel, hif.s1Fwd, hif.s2Fwd} !==
          {exp_stall, exp_flush, exp_pc, exp_s1, exp_s2}) begin
        n_errors++; $display("FAIL random_outputs[%0d]: got %b want %b", i,
          {hif.stall, hif.flushID, hif.pcSel, hif.s1Fwd, hif.s2Fwd},
          {exp_stall, exp_flush, exp_pc, exp_s1, exp_s2});
      end
      n_checks++;
      if (int'(stallCount) != m_stall_cnt || int'(flushCount) != m_flush_cnt) begin
        n_errors++; $display("FAIL random_counters[%0d]: got %0d/%0d want %0d/%0d", i,
          stallCount, flushCount, m_stall_cnt, m_flush_cnt);
      end
      prev_stall = exp_stall && !reset;
      tick();
    end
    reset = 0;
  endtask

  task automatic test_flush_saturation();
    reset_dut();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);                  // branch every cycle: flush every cycle
    for (int i = 1; i <= 65541; i++) begin
      tick();
      if (i == 65534 || i == 65535 || i == 65541) begin
        #1;
        n_checks++;
        if (flushCount !== ((i == 65534) ? 16'hFFFE : 16'hFFFF)) begin
          n_errors++; $display("FAIL flush_saturate[%0d]: got %h want %h", i, flushCount,
            (i == 65534) ? 16'hFFFE : 16'hFFFF);
        end
      end
    end
    idle(); tick(); tick();
  endtask

  task automatic test_stall_saturation();
    reset_dut();
    for (int i = 1; i <= 20; i++) begin
      hifs.instValid = 1; hifs.dRegAddr = 4'd5; hifs.s1RegAddr = 4'd1; hifs.s2RegAddr = 4'd0;
      hifs.s1Used = 1; hifs.s2Used = 0; hifs.regFileWrtEn = 1; hifs.isLoad = 1; hifs.brTaken = 0;
      @(posedge clk); @(negedge clk);
      hifs.dRegAddr = 4'd7; hifs.s1RegAddr = 4'd5; hifs.isLoad = 0;
      #1;
      if (i == 1) begin
        n_checks++;
        if (hifs.stall !== 1'b1) begin
          n_errors++; $display("FAIL small_stall: got %b want 1", hifs.stall);
        end
      end
      @(posedge clk); @(negedge clk);
      if (i == 14 || i == 15 || i == 20) begin
        #1;
        n_checks++;
        if (stallCount_s !== ((i == 14) ? 4'hE : 4'hF)) begin
          n_errors++; $display("FAIL stall_saturate[%0d]: got %h want %h", i, stallCount_s,
            (i == 14) ? 4'hE : 4'hF);
        end
      end
    end
    hifs.instValid = 0; hifs.s1Used = 0; hifs.regFileWrtEn = 0;
  endtask

  initial begin
    idle();
    hifs.instValid = 0; hifs.dRegAddr = 0; hifs.s1RegAddr = 0; hifs.s2RegAddr = 0;
    hifs.s1Used = 0; hifs.s2Used = 0; hifs.regFileWrtEn = 0; hifs.isLoad = 0; hifs.brTaken = 0;
    m_hist[0] = '{0, 0, 0}; m_hist[1] = '{0, 0, 0};
    m_kill = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    @(negedge clk);
    test_reset();
    test_ex_forward();
    test_mem_forward();
    test_load_use();
    test_immediate();
    test_branch();
    test_branch_load_use();
    test_random();
    test_stall_saturation();
    test_flush_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
- Pipeline sequencing unit for the decode/execute datapath.
- Tracks in-flight register writers in the EX and MEM stages and drives the forwarding selects for operands s1/s2.
- Stalls decode on load-use hazards and flushes wrong-path instructions after a taken branch or JAL.
- Sits beside the instruction decoder. Consumes its register addresses and type flags, and drives PC/IF-ID hold, bubble insertion and operand muxes.

Parameters:
REG_ADDR_WIDTH, 4, register address width
CNT_WIDTH, 16, width of saturating performance counters

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
instValid  input  1  decode stage holds a real instruction
dRegAddr  input  REG_ADDR_WIDTH  destination of decode instruction
s1RegAddr  input  REG_ADDR_WIDTH  source 1 of decode instruction
s2RegAddr  input  REG_ADDR_WIDTH  source 2 of decode instruction
s1Used  input  1  decode instruction reads s1
s2Used  input  1  decode instruction reads s2 as a register (0 for immediate forms)
regFileWrtEn  input  1  decode instruction writes dRegAddr
isLoad  input  1  decode instruction is a load
brTaken  input  1  EX-stage branch/JAL redirects PC this cycle
stall  output  1  hold PC and IF/ID register; insert bubble into EX
flushID  output  1  kill instruction in decode (do not enter EX)
pcSel  output  1  PC mux selects redirect target
s1Fwd  output  2  00 regfile, 01 EX result, 10 MEM result
s2Fwd  output  2  same encoding as s1Fwd
stallCount  output  CNT_WIDTH  cycles with stall=1
flushCount  output  CNT_WIDTH  cycles with flushID=1

Behaviour:
- Scoreboard: two slots, exSlot and memSlot, each {valid, addr, isLoad}.
- Per clock, memSlot <= exSlot.
- Per clock, exSlot <= {instValid & regFileWrtEn, dRegAddr, isLoad} only when stall=0 and flushID=0. Otherwise exSlot <= invalid (bubble).
- Slot match: s1 matches a slot when s1Used & slot.valid & (s1RegAddr == slot.addr). s2 matches likewise with s2Used. Register 0 is not special.
- Load-use hazard (combinational): instValid & exSlot.valid & exSlot.isLoad & (s1 matches exSlot | s2 matches exSlot).
- stall = load-use hazard & ~flushID. One cycle is sufficient: next cycle the load sits in memSlot and forwards from MEM.
- Forwarding (combinational, per operand):
  - 01 if it matches a non-load exSlot.
  - else 10 if it matches memSlot.
  - else 00.
  - EX has priority over MEM when both match.
  - Fwd is 00 whenever the operand is unused.
- FSM states: RUN, KILL.
  - RUN: pcSel = brTaken; flushID = brTaken; brTaken=1 -> KILL, else stay RUN.
  - KILL: flushID=1, pcSel=0, brTaken ignored (EX holds a bubble); always -> RUN.
  - Net effect: a taken branch kills exactly the two younger instructions, i.e. two consecutive flushID cycles.
- Simultaneous events:
  - brTaken with a load-use hazard: flush wins, stall=0.
  - A stalled instruction re-presents next cycle with the same addresses.
  - stall and flushID are never both 1.
- Counters: +1 per cycle with the respective output high; saturate at all-ones (no wrap).
- Reset (sync, overrides all):
  - Both slots invalid, state RUN, counters 0.
  - Outputs in reset cycle and first cycle after: stall=0, flushID=0, pcSel=0, s1Fwd=s2Fwd=00 (slots invalid). This holds provided brTaken=0.
  - Reset asserted during KILL returns to RUN with no residual flush.
- No latency beyond stated: all outputs combinational from current inputs and registered state.

Test Plan:
- ADD r3 written, next inst reads s1=r3, s2=r3 -> cycle 2: s1Fwd=01, s2Fwd=01, stall=0. Unrelated inst between -> s1Fwd=10.
- LW r5, then ADD reading s2=r5 -> one cycle stall=1 (stallCount=1), bubble enters EX. Next cycle s2Fwd=10, stall=0.
- LW r5, then ADDI with s2Used=0, s2RegAddr=r5, s1=r2 -> stall=0, s2Fwd=00.
- brTaken=1 in RUN -> pcSel=1, flushID=1 that cycle and next, flushCount=2. brTaken=1 in the KILL cycle is ignored.
- brTaken=1 coinciding with a load-use hazard -> stall=0, flushID=1. Reset asserted in KILL -> next cycle flushID=0, counters 0.
- Force stall 2^16+5 cycles (CNT_WIDTH=16) -> stallCount holds 16'hFFFF.
